// File: rtl/chunked_serial_adder_if.sv
// Operand and result channels of the chunked serial adder.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and
// ready are both high; the sender holds its payload stable from valid until that edge.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract using one CHUNK-bit adder slice, LSB chunk first.
// Operands are shifted right one chunk per RUN cycle; result chunks shift in from the top.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_serial_adder_if.slave  bus,
  output logic [1:0]             dbg_state
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic                   in_ready_w;
  logic                   out_valid_w;
  logic                   accept;
  logic                   last_chunk;
  logic [CHUNK:0]         slice;
  logic [WIDTH+CHUNK-1:0] res_wide;
  logic [WIDTH-1:0]       res_next;

  assign in_ready_w  = rst_n && (state_q == IDLE);
  assign out_valid_w = rst_n && (state_q == DONE);
  assign accept      = bus.in_valid && in_ready_w;
  assign last_chunk  = (cnt_q == CW'(N - 1));

  // The low chunk of the shifting operand registers is always the chunk being added.
  assign slice    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign res_wide = {slice[CHUNK-1:0], res_q};
  assign res_next = res_wide[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          res_q   <= res_next;
          carry_q <= slice[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (last_chunk) begin
            // On the final chunk the low bits of a_q/b_q hold the operand MSBs.
            sum_q  <= res_next;
            cout_q <= slice[CHUNK];
            ovf_q  <= (a_q[CHUNK-1] == b_q[CHUNK-1]) && (slice[CHUNK-1] != a_q[CHUNK-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;
endmodule
